pio_in_edge_irq: RTL

PIO_IN_EDGE_IRQ -- requirements
Module: pio_in_edge_irq

---
 rtl/pio_in_edge_irq_pkg.sv | 21 ++
 rtl/pio_debounce_ch.sv | 64 ++++++
 rtl/pio_in_edge_irq.sv | 96 +++++++++
 3 files changed

// File: rtl/pio_in_edge_irq_pkg.sv
// rtl/pio_in_edge_irq_pkg.sv - shared constants for the edge-capturing PIO input block
package pio_in_edge_irq_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_PEND = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int PRIME_CYCLES = 2;

  function automatic int cnt_width(input int max_count);
    int w;
    w = $clog2(max_count + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pio_debounce_ch.sv
// rtl/pio_debounce_ch.sv - one input channel: synchronizer, debounce counter, stable flop, edge detect
module pio_debounce_ch
  import pio_in_edge_irq_pkg::*;
#(
  parameter int EDGE_TYPE       = 1,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic prime,
  input  logic in_bit,
  output logic stable,
  output logic edge_evt
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          differ;
  logic          accept;

  assign differ = (s2 != stable);
  assign accept = !prime && differ && (cnt == CNT_LAST);

  always_comb begin
    edge_evt = 1'b0;
    if (accept) begin
      case (EDGE_TYPE)
        EDGE_RISE: edge_evt = s2;
        EDGE_FALL: edge_evt = ~s2;
        default:   edge_evt = 1'b1;
      endcase
    end
  end

  // During priming stable copies s1, i.e. the value s2 takes on the same edge,
  // so a level held through reset release is already stable when priming ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= in_bit;
      s2 <= s1;
      if (prime) begin
        stable <= s1;
        cnt    <= '0;
      end else if (accept) begin
        stable <= s2;
        cnt    <= '0;
      end else if (!differ) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pio_in_edge_irq.sv
// rtl/pio_in_edge_irq.sv - debounced PIO input port with sticky edge capture and level irq
module pio_in_edge_irq
  import pio_in_edge_irq_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int EDGE_TYPE       = 1,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [1:0]       prime_cnt;
  logic             prime;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] clr_bits;
  logic             wr_en;
  logic [31:0]      rd_next;

  assign prime = (prime_cnt != 2'(PRIME_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prime_cnt <= 2'd0;
    end else if (prime) begin
      prime_cnt <= prime_cnt + 2'd1;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    pio_debounce_ch #(
      .EDGE_TYPE       (EDGE_TYPE),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .prime    (prime),
      .in_bit   (in_port[g]),
      .stable   (stable[g]),
      .edge_evt (edge_evt[g])
    );
  end

  if (WIDTH < 32) begin : g_wd_pad
    logic unused_writedata_hi;
    assign unused_writedata_hi = ^writedata[31:WIDTH];
  end

  assign wr_en    = chipselect & ~write_n;
  assign clr_bits = (wr_en && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;
  assign pending  = edge_capture & irq_mask;
  assign irq      = |pending;

  // A new event is ORed in after the clear so it survives a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_en && (address == ADDR_MASK)) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      edge_capture <= (edge_capture & ~clr_bits) | edge_evt;
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA: rd_next[WIDTH-1:0] = stable;
      ADDR_PEND: rd_next[WIDTH-1:0] = pending;
      ADDR_MASK: rd_next[WIDTH-1:0] = irq_mask;
      default:   rd_next[WIDTH-1:0] = edge_capture;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

endmodule
